// File: rtl/mem_access_master_if.sv
// Client and memory-port signal bundle for mem_access_master.
//   master modport: the view of mem_access_master itself.
//   slave modport : the view of the surrounding client + memory.
// Client side : req_valid/req_ready/req_addr/req_size/req_write,
//               wr_valid/wr_ready/wr_data, rsp_valid/rsp_data/rsp_last/rsp_err.
// Memory side : mem_enable/mem_addr/mem_size/mem_rd_wr/mem_din out,
//               mem_dout/mem_busy in.
interface mem_access_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_write;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_rd_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_busy;

    modport master (
        input  req_valid, req_addr, req_size, req_write, wr_valid, wr_data,
               mem_dout, mem_busy,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
               mem_enable, mem_addr, mem_size, mem_rd_wr, mem_din
    );

    modport slave (
        output req_valid, req_addr, req_size, req_write, wr_valid, wr_data,
               mem_dout, mem_busy,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
               mem_enable, mem_addr, mem_size, mem_rd_wr, mem_din
    );
endinterface

// File: rtl/mem_access_master.sv
// Initiator for the instruction/data memory port. Accepts one client access
// at a time, range/alignment checks it, buffers write bursts (up to 8 beats)
// and sequences the memory enable/addr/size/rd_wr/data_in signals. Read beats
// return as a registered response stream; writes and rejected requests return
// a single last beat.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_access_master_if.master (client request/write/response and
//           memory port signals)
module mem_access_master #(
    parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
    parameter int unsigned MEM_DEPTH = 2**20
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_master_if.master bus
);

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_4WORD = 2'b10;
    localparam logic [1:0] SZ_8WORD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_FILL,
        S_ISSUE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q [8];
    logic [31:0] buf_d [8];
    // rd_cap_q: memory is driving a read beat this cycle; rd_last_q: it is the final one
    logic        rd_cap_q, rd_cap_d;
    logic        rd_last_q, rd_last_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_ready;
    logic        wr_ready;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_rd_wr;
    logic [31:0] mem_din;

    logic [32:0] addr33;
    logic [32:0] base33;
    logic [32:0] offset33;
    logic [32:0] span33;
    logic        req_ok;
    logic [2:0]  last_beat;

    function automatic logic [2:0] beats_m1(input logic [1:0] sz);
        case (sz)
            SZ_4WORD: return 3'd3;
            SZ_8WORD: return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    // Acceptance check, 33 bits wide so neither the subtraction nor the end
    // bound can wrap around the 32-bit address space.
    always_comb begin
        addr33   = {1'b0, bus.req_addr};
        base33   = {1'b0, MEM_BASE};
        offset33 = addr33 - base33;
        case (bus.req_size)
            SZ_BYTE:  span33 = 33'd1;
            SZ_WORD:  span33 = 33'd4;
            SZ_4WORD: span33 = 33'd16;
            default:  span33 = 33'd32;
        endcase
        req_ok = ((bus.req_size == SZ_BYTE) || (bus.req_addr[1:0] == 2'b00))
              && (addr33 >= base33)
              && ((offset33 + span33) <= 33'(MEM_DEPTH));
    end

    assign last_beat = beats_m1(size_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        rd_cap_d  = 1'b0;
        rd_last_d = 1'b0;
        // Read beats are re-timed one cycle behind the memory's data_out.
        rsp_valid_d = rd_cap_q;
        rsp_data_d  = '0;
        if (rd_cap_q) begin
            rsp_data_d = (size_q == SZ_BYTE) ? {24'h0, bus.mem_dout[7:0]} : bus.mem_dout;
        end
        rsp_last_d = rd_last_q;
        rsp_err_d  = 1'b0;

        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        mem_enable = 1'b0;
        mem_addr   = '0;
        mem_size   = '0;
        mem_rd_wr  = 1'b1;
        mem_din    = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = !bus.mem_busy;
                if (bus.req_valid && !bus.mem_busy) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    write_d = bus.req_write;
                    cnt_d   = '0;
                    if (!req_ok) begin
                        state_d     = S_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            S_FILL: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    buf_d[cnt_q] = bus.wr_data;
                    if (cnt_q == last_beat) begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_ISSUE, S_BURST: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q;
                mem_size   = size_q;
                mem_rd_wr  = !write_q;
                mem_din    = buf_q[cnt_q];
                rd_cap_d   = !write_q;
                rd_last_d  = (cnt_q == last_beat);
                if (cnt_q == last_beat) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    // A write's single response lands in the cycle after its last beat.
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                    end
                end else begin
                    state_d = S_BURST;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            S_DRAIN: begin
                // Hold off IDLE until the final response beat is on the outputs.
                if (rsp_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            rd_cap_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            rd_cap_q    <= rd_cap_d;
            rd_last_q   <= rd_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.wr_ready   = wr_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.mem_enable = mem_enable;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_size   = mem_size;
    assign bus.mem_rd_wr  = mem_rd_wr;
    assign bus.mem_din    = mem_din;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: a byte-array memory model answers
// the memory port, and a separate reference byte array predicts read data,
// acceptance legality, beat counts and cycle timing for every access.
module tb_mem_access_master;

    localparam logic [31:0] BASE     = 32'h8002_0000;
    localparam int unsigned DEPTH    = 2**20;
    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_WORD  = 2'b01;
    localparam logic [1:0]  SZ_4WORD = 2'b10;
    localparam logic [1:0]  SZ_8WORD = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_master_if bus ();

    mem_access_master #(
        .MEM_BASE  (BASE),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit   [7:0]  dev_mem [DEPTH];
    bit   [7:0]  ref_mem [DEPTH];
    logic [31:0] wbeats  [8];

    // Memory model: one-cycle read latency, beat k of a burst at addr + 4k.
    logic        mm_prev_en;
    int unsigned mm_k;
    int unsigned mm_beat;
    int unsigned mm_off;
    assign mm_beat = mm_prev_en ? mm_k + 1 : 0;
    assign mm_off  = bus.mem_addr - BASE + 4 * mm_beat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_prev_en   <= 1'b0;
            mm_k         <= 0;
            bus.mem_dout <= '0;
        end else begin
            mm_prev_en   <= bus.mem_enable;
            bus.mem_dout <= $urandom;
            if (bus.mem_enable) begin
                mm_k <= mm_beat;
                if (bus.mem_rd_wr) begin
                    if (bus.mem_size == SZ_BYTE && mm_off < DEPTH)
                        bus.mem_dout <= ($urandom & 32'hffff_ff00) | {24'h0, dev_mem[mm_off]};
                    else if (mm_off < DEPTH - 3)
                        bus.mem_dout <= {dev_mem[mm_off+3], dev_mem[mm_off+2],
                                         dev_mem[mm_off+1], dev_mem[mm_off]};
                end else begin
                    if (bus.mem_size == SZ_BYTE && mm_off < DEPTH)
                        dev_mem[mm_off] <= bus.mem_din[7:0];
                    else if (mm_off < DEPTH - 3)
                        for (int i = 0; i < 4; i++) dev_mem[mm_off+i] <= bus.mem_din[8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned beats(input logic [1:0] sz);
        return (sz == SZ_4WORD) ? 4 : (sz == SZ_8WORD) ? 8 : 1;
    endfunction

    function automatic bit ref_legal(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned la;
        longint unsigned span;
        la   = {32'h0, a};
        span = (sz == SZ_BYTE) ? 1 : 4 * beats(sz);
        if (sz != SZ_BYTE && (la % 4) != 0) return 1'b0;
        if (la < BASE) return 1'b0;
        return (la - BASE + span) <= DEPTH;
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned o);
        return {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
    endfunction

    task automatic check_idle_outputs(input string p);
        check($sformatf("%s_req_ready", p),  32'(bus.req_ready),  32'd1);
        check($sformatf("%s_wr_ready", p),   32'(bus.wr_ready),   32'd0);
        check($sformatf("%s_rsp_valid", p),  32'(bus.rsp_valid),  32'd0);
        check($sformatf("%s_rsp_data", p),   bus.rsp_data,        32'd0);
        check($sformatf("%s_rsp_last", p),   32'(bus.rsp_last),   32'd0);
        check($sformatf("%s_rsp_err", p),    32'(bus.rsp_err),    32'd0);
        check($sformatf("%s_mem_enable", p), 32'(bus.mem_enable), 32'd0);
        check($sformatf("%s_mem_addr", p),   bus.mem_addr,        32'd0);
        check($sformatf("%s_mem_size", p),   32'(bus.mem_size),   32'd0);
        check($sformatf("%s_mem_rd_wr", p),  32'(bus.mem_rd_wr),  32'd1);
        check($sformatf("%s_mem_din", p),    bus.mem_din,         32'd0);
    endtask

    // Drives one access end to end (write beats from wbeats[], spaced by gap
    // idle cycles; mem_busy held for busy_cycles first) and checks it.
    task automatic do_access(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                             input int unsigned gap, input int unsigned busy_cycles);
        int unsigned n, taken, idle_run, bcnt, off;
        bit          legal, accepted, done;
        int          a_cyc, last_cyc, last_take, first_en;
        int          en_cyc[$];
        logic [31:0] en_addr[$];
        logic [31:0] en_din[$];
        logic [1:0]  en_size[$];
        logic        en_rw[$];
        int          rs_cyc[$];
        logic [31:0] rs_data[$];
        logic        rs_last[$];
        logic        rs_err[$];
        logic [31:0] exp_d;

        n = beats(size);
        legal = ref_legal(addr, size);
        accepted = 1'b0; done = 1'b0;
        a_cyc = -1; last_cyc = -1; last_take = -1;
        taken = 0; idle_run = gap; bcnt = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            bus.mem_busy = (bcnt < busy_cycles);
            if (!accepted) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = addr;
                bus.req_size  = size;
                bus.req_write = wr;
                bus.wr_valid  = 1'b1;
                bus.wr_data   = 32'hdead_beef;
            end else begin
                bus.req_valid = 1'b0;
                bus.req_addr  = $urandom;
                bus.req_size  = 2'($urandom);
                bus.req_write = 1'($urandom);
                bus.wr_valid  = wr ? (idle_run >= gap) : 1'($urandom);
                bus.wr_data   = wbeats[taken % 8];
            end
            #1;
            if (bus.wr_valid && bus.wr_ready) begin
                taken++; idle_run = 0; last_take = cyc;
            end else if (accepted && !bus.wr_valid) begin
                idle_run++;
            end
            if (!accepted) begin
                if (bcnt < busy_cycles) begin
                    check("busy_blocks_req", 32'(bus.req_ready), 32'd0);
                    bcnt++;
                end
                if (bus.req_valid && bus.req_ready) begin
                    accepted = 1'b1; a_cyc = cyc;
                end
            end
            if (bus.mem_enable) begin
                en_cyc.push_back(cyc); en_addr.push_back(bus.mem_addr);
                en_din.push_back(bus.mem_din); en_size.push_back(bus.mem_size);
                en_rw.push_back(bus.mem_rd_wr);
            end
            if (bus.rsp_valid) begin
                rs_cyc.push_back(cyc); rs_data.push_back(bus.rsp_data);
                rs_last.push_back(bus.rsp_last); rs_err.push_back(bus.rsp_err);
            end
            if (last_cyc >= 0 && cyc == last_cyc + 1) begin
                check("ready_after_last", 32'(bus.req_ready), 32'd1);
                done = 1'b1;
            end else if (last_cyc < 0 && bus.rsp_valid && bus.rsp_last) begin
                last_cyc = cyc;
                check("ready_low_at_last", 32'(bus.req_ready), 32'd0);
            end
        end
        bus.wr_valid = 1'b0;
        check("access_completed", 32'(done), 32'd1);
        check("wr_beats_taken", taken, (legal && wr) ? n : 0);
        off = addr - BASE;

        if (!legal) begin
            check("err_en_cnt", en_cyc.size(), 0);
            check("err_rsp_cnt", rs_cyc.size(), 1);
            if (rs_cyc.size() > 0) begin
                check("err_rsp_cyc", 32'(rs_cyc[0] - a_cyc), 32'd1);
                check("err_rsp_err", 32'(rs_err[0]), 32'd1);
                check("err_rsp_last", 32'(rs_last[0]), 32'd1);
                check("err_rsp_data", rs_data[0], 32'd0);
            end
        end else begin
            first_en = wr ? last_take + 1 : a_cyc + 1;
            check("en_cnt", en_cyc.size(), n);
            for (int k = 0; k < en_cyc.size() && k < int'(n); k++) begin
                check($sformatf("en_cyc[%0d]", k), 32'(en_cyc[k] - first_en), 32'(k));
                check($sformatf("en_addr[%0d]", k), en_addr[k], addr);
                check($sformatf("en_size[%0d]", k), 32'(en_size[k]), 32'(size));
                check($sformatf("en_rd_wr[%0d]", k), 32'(en_rw[k]), 32'(!wr));
                if (wr && size == SZ_BYTE)
                    check("en_din_byte", 32'(en_din[k][7:0]), 32'(wbeats[0][7:0]));
                else if (wr)
                    check($sformatf("en_din[%0d]", k), en_din[k], wbeats[k]);
            end
            if (wr) begin
                check("wr_rsp_cnt", rs_cyc.size(), 1);
                if (rs_cyc.size() > 0) begin
                    check("wr_rsp_cyc", 32'(rs_cyc[0] - first_en), n);
                    check("wr_rsp_data", rs_data[0], 32'd0);
                    check("wr_rsp_last", 32'(rs_last[0]), 32'd1);
                    check("wr_rsp_err", 32'(rs_err[0]), 32'd0);
                end
                if (size == SZ_BYTE) ref_mem[off] = wbeats[0][7:0];
                else for (int k = 0; k < int'(n); k++)
                    for (int i = 0; i < 4; i++) ref_mem[off + 4*k + i] = wbeats[k][8*i +: 8];
            end else begin
                check("rd_rsp_cnt", rs_cyc.size(), n);
                for (int k = 0; k < rs_cyc.size() && k < int'(n); k++) begin
                    exp_d = (size == SZ_BYTE) ? {24'h0, ref_mem[off]} : ref_word(off + 4*k);
                    check($sformatf("rd_cyc[%0d]", k), 32'(rs_cyc[k] - first_en), 32'(k + 2));
                    check($sformatf("rd_data[%0d]", k), rs_data[k], exp_d);
                    check($sformatf("rd_last[%0d]", k), 32'(rs_last[k]), 32'(k == int'(n) - 1));
                    check($sformatf("rd_err[%0d]", k), 32'(rs_err[k]), 32'd0);
                end
            end
        end
    endtask

    task automatic reset_mid_burst();
        int unsigned en_seen;
        bit          accepted;
        en_seen = 0; accepted = 1'b0;
        bus.mem_busy = 1'b0; bus.wr_valid = 1'b0;
        bus.req_addr = BASE; bus.req_size = SZ_8WORD; bus.req_write = 1'b0;
        for (int t = 0; t < 60 && en_seen < 3; t++) begin
            @(negedge clk);
            bus.req_valid = !accepted;
            #1;
            if (bus.req_valid && bus.req_ready) accepted = 1'b1;
            if (bus.mem_enable) en_seen++;
        end
        bus.req_valid = 1'b0;
        check("rst_reached_beat3", en_seen, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (t == 2) rst_n = 1'b1;
            #1;
            check("rst_no_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_no_rsp_last", 32'(bus.rsp_last), 32'd0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_write = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("post_reset");

        // word read, word write + read-back
        do_access(BASE, SZ_WORD, 1'b0, 0, 0);
        wbeats[0] = 32'haaaa_aaaa;
        do_access(BASE + 4, SZ_WORD, 1'b1, 0, 0);
        do_access(BASE + 4, SZ_WORD, 1'b0, 0, 0);

        // byte writes then byte reads
        for (int i = 0; i < 4; i++) begin
            wbeats[0] = {$urandom_range(0, 255), 8'h00} | 32'(8'h11 * i);
            do_access(BASE + i, SZ_BYTE, 1'b1, 0, 0);
        end
        for (int i = 0; i < 4; i++) do_access(BASE + i, SZ_BYTE, 1'b0, 0, 0);

        // gapped 8-word burst write, then 4-word and 8-word reads
        wbeats = '{32'haaaa_aaaa, 32'hbbbb_bbbb, 32'hcccc_cccc, 32'hdddd_dddd,
                   32'heeee_eeee, 32'hffff_ffff, 32'h0000_0000, 32'h1111_1111};
        do_access(BASE, SZ_8WORD, 1'b1, 2, 0);
        do_access(BASE, SZ_4WORD, 1'b0, 0, 0);
        do_access(BASE, SZ_8WORD, 1'b0, 0, 0);

        // rejected requests, including writes whose beats must never be taken
        do_access(BASE + 2, SZ_WORD, 1'b0, 0, 0);
        do_access(BASE + DEPTH - 16, SZ_8WORD, 1'b0, 0, 0);
        do_access(BASE + DEPTH - 16, SZ_8WORD, 1'b1, 0, 0);
        do_access(32'h7fff_ffff, SZ_BYTE, 1'b0, 0, 0);
        do_access(32'h7fff_ffff, SZ_BYTE, 1'b1, 0, 0);
        do_access(32'h7fff_ffff, SZ_WORD, 1'b0, 0, 0);
        // exact end-of-memory fits
        do_access(BASE + DEPTH - 32, SZ_8WORD, 1'b0, 0, 0);
        do_access(BASE + DEPTH - 1, SZ_BYTE, 1'b1, 0, 0);
        do_access(BASE + DEPTH, SZ_BYTE, 1'b0, 0, 0);

        // request held off by mem_busy
        do_access(BASE + 4, SZ_WORD, 1'b0, 0, 3);

        reset_mid_burst();
        do_access(BASE, SZ_4WORD, 1'b0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int unsigned pick;
            sz   = 2'($urandom);
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = BASE - $urandom_range(1, 64);
            else if (pick == 1) a = BASE + DEPTH - $urandom_range(1, 40);
            else                a = BASE + $urandom_range(0, 95);
            if (sz != SZ_BYTE && $urandom_range(0, 4) != 0) a = a & 32'hffff_fffc;
            for (int j = 0; j < 8; j++) wbeats[j] = $urandom;
            do_access(a, sz, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
